mean_sched: RTL and testbench
=============================

# mean_sched

Round-robin scheduler that shares one `mean` datapath instance between `NUM_REQ` requesters. Each requester presents a bus of `BUS_WIDTH` samples with a valid/ready handshake. The scheduler launches at most one bus per cycle into `mean` and tracks in-flight requests by requester ID. It returns each result tagged with the ID of the requester that issued it. It sits between the requester fabric and the `mean` instance.

## Interface
Parameters:
- `NUM_REQ`, default 4: number of requesters, 2..16.
- `BUS_WIDTH`, default 2: samples per request; must match the `mean` instance.
- `DATA_WIDTH`, default `data_width` from `mean_pkg`: bits per sample and per result.
- `MAX_INFLIGHT`, default 4: tag FIFO depth and in-flight limit, power of two, ≥2.
- `ID_W`, default `$clog2(NUM_REQ)`: width of the requester ID.

Ports:
- `clk`  in  1  — the only clock.
- `rst`  in  1  — reset, synchronous and active-high.
- `en`  in  1  — when low, no new launches are made; in-flight results still return.
- `req_valid`  in  NUM_REQ  — per-requester request valid.
- `req_ready`  out  NUM_REQ  — per-requester accept; one-hot or zero.
- `req_data`  in  NUM_REQ*BUS_WIDTH*DATA_WIDTH  — requester i occupies slice i; sample j lies at `[(i*BUS_WIDTH+j)*DATA_WIDTH +: DATA_WIDTH]`.
- `mean_i_valid`  out  1  — drives `mean.i_valid`.
- `mean_i_data`  out  BUS_WIDTH*DATA_WIDTH  — drives `mean.i_data`; sample j is in slice j.
- `mean_o_valid`  in  1  — from `mean.o_valid`.
- `mean_o_data`  in  DATA_WIDTH  — from `mean.o_data`.
- `res_valid`  out  1  — result pulse.
- `res_data`  out  DATA_WIDTH  — the result value.
- `res_id`  out  ID_W  — requester ID owning `res_data`.
- `inflight`  out  $clog2(MAX_INFLIGHT)+1  — current in-flight count.
- `err_orphan`  out  1  — sticky flag: a result arrived with no tag pending.

## Operation
- **Eligibility:** requester i is eligible when `req_valid[i]`, `en`, and at least one of the following holds:
  - `inflight < MAX_INFLIGHT`;
  - `inflight == MAX_INFLIGHT` and `mean_o_valid` is high this cycle (a pop frees a slot).
- **Arbitration:** round-robin with a `last` pointer. Priority starts at `last+1` and wraps modulo `NUM_REQ`.
  - `req_ready` is combinational and one-hot: the ready bit goes to the first eligible requester in priority order.
  - A transfer occurs when `req_valid[i] & req_ready[i]`. On transfer, `last` becomes i.
  - `last` holds when there is no transfer.
- **Launch:** on transfer, the selected slice of `req_data` is registered into `mean_i_data`, and `mean_i_valid` is driven high for exactly one cycle. In the same cycle, ID i is pushed into the tag FIFO.
- **Return:** on `mean_o_valid`, a tag is popped from the tag FIFO. `res_data` is set to the registered `mean_o_data`, `res_id` to the popped tag, and `res_valid` is high for one cycle. Results come back in launch order, because `mean` is in-order.
- **No backpressure on results:** the consumer must accept `res_valid` every cycle it is asserted.
- **Counter:** `inflight` changes by +1 on a push only, −1 on a pop only, and 0 when a push and a pop happen together. The count never exceeds `MAX_INFLIGHT`.
- **Orphan result:** if `mean_o_valid` arrives while the FIFO is empty, the block does the following:
  - sets `err_orphan`, which stays high until `rst`;
  - outputs `res_valid` with `res_id = 0` and the data passed through;
  - leaves `inflight` at 0.
- **Enable:** deasserting `en` stops new transfers from the next evaluation; requests already launched complete normally.
- **Reset:** applies on a rising `clk` with `rst` high.
  - Outputs: `req_ready = 0`, `mean_i_valid = 0`, `mean_i_data = 0`, `res_valid = 0`, `res_data = 0`, `res_id = 0`, `inflight = 0`, `err_orphan = 0`.
  - Internal state: `last = NUM_REQ-1`, so requester 0 has first priority. The tag FIFO is emptied.
  - Reset during operation discards all in-flight tags. Results that `mean` emits after reset are treated as orphans; the system resets `mean` on the same `rst`.

## Timing
- `req_ready` is valid combinationally in the same cycle as `req_valid`, `inflight`, and `mean_o_valid`.
- Transfer at cycle N gives `mean_i_valid` high at cycle N+1.
- `mean_o_valid` at cycle M gives `res_valid`, `res_data`, and `res_id` at cycle M+1.
- Total latency is 2 + (latency of `mean`) cycles.
- Throughput: one transfer per cycle while `inflight < MAX_INFLIGHT`.
- `inflight` is registered and reflects pushes and pops from the previous edge.

## Test plan
- **Single request:** after reset, requester 2 presents samples {4,6}. Expected:
  - `req_ready = 4'b0100` in the same cycle;
  - `mean_i_valid` one cycle later with data {4,6};
  - after the `mean` latency, `res_data = 5`, `res_id = 2`;
  - `inflight` goes 0 → 1 → 0.
- **Round-robin fairness:** all four requesters hold `req_valid` continuously with `MAX_INFLIGHT` not limiting. Expected grant order is 0, 1, 2, 3, 0, 1, …, and the `res_id` sequence matches the grant order.
- **In-flight limit:** `MAX_INFLIGHT = 4` and the `mean` output is stalled by the bench model. Expected:
  - exactly 4 transfers, then `req_ready = 0` with `inflight = 4`;
  - on the first `mean_o_valid`, a new transfer occurs in the same cycle and `inflight` stays at 4.
- **Enable gating:** deassert `en` mid-stream with 2 requests in flight. Expected: no new `mean_i_valid`, both results are returned, `inflight` reaches 0, and when `en` is reasserted, arbitration resumes from `last+1`.
- **Orphan result:** inject `mean_o_valid` with the FIFO empty and data 0x3C. Expected: `res_valid` with `res_id = 0` and `res_data = 0x3C`; `err_orphan` goes to 1 and stays set until `rst`.
- **Reset mid-operation:** assert `rst` for 1 cycle while `inflight = 3`. Expected: all outputs take their reset values on the next edge, `inflight = 0`, and the first grant after reset goes to requester 0.

Source files
------------

// File: rtl/mean_sched.sv
// Round-robin front end that shares one `mean` datapath between NUM_REQ requesters.
// Results are returned in launch order and tagged with the ID of the requester that issued them.

package mean_pkg;
    localparam int data_width = 8;
endpackage

module mean_sched #(
    parameter int NUM_REQ      = 4,
    parameter int BUS_WIDTH    = 2,
    parameter int DATA_WIDTH   = mean_pkg::data_width,
    parameter int MAX_INFLIGHT = 4,
    parameter int ID_W         = $clog2(NUM_REQ)
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  en,
    input  logic [NUM_REQ-1:0]                    req_valid,
    output logic [NUM_REQ-1:0]                    req_ready,
    input  logic [NUM_REQ*BUS_WIDTH*DATA_WIDTH-1:0] req_data,
    output logic                                  mean_i_valid,
    output logic [BUS_WIDTH*DATA_WIDTH-1:0]       mean_i_data,
    input  logic                                  mean_o_valid,
    input  logic [DATA_WIDTH-1:0]                 mean_o_data,
    output logic                                  res_valid,
    output logic [DATA_WIDTH-1:0]                 res_data,
    output logic [ID_W-1:0]                       res_id,
    output logic [$clog2(MAX_INFLIGHT):0]         inflight,
    output logic                                  err_orphan
);

    localparam int SLICE = BUS_WIDTH * DATA_WIDTH;
    localparam int PW    = $clog2(MAX_INFLIGHT);
    localparam int CW    = PW + 1;
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_INFLIGHT);

    logic [ID_W-1:0]  last;
    logic [ID_W-1:0]  sel_id;
    logic [ID_W-1:0]  cand;
    logic             sel_found;
    logic             can_push;
    logic             push;
    logic             pop;
    logic [SLICE-1:0] sel_data;
    logic [ID_W-1:0]  tag_mem [MAX_INFLIGHT];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;

    // A full FIFO may still accept a launch when a result pops in the same cycle.
    // NOTE: every signal written here gets a default first, so no latch is inferred.
    always_comb begin
        can_push  = en && !rst &&
                    ((inflight < MAX_CNT) || ((inflight == MAX_CNT) && mean_o_valid));
        sel_found = 1'b0;
        sel_id    = '0;
        cand      = '0;
        req_ready = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = ID_W'((int'(last) + k) % NUM_REQ);
            if (can_push && !sel_found && req_valid[cand]) begin
                sel_found = 1'b1;
                sel_id    = cand;
            end
        end
        if (sel_found) req_ready[sel_id] = 1'b1;
    end

    assign sel_data = req_data[int'(sel_id)*SLICE +: SLICE];
    assign push     = sel_found;
    assign pop      = mean_o_valid && (inflight != '0);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            last         <= ID_W'(NUM_REQ - 1);
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            inflight     <= '0;
            mean_i_valid <= 1'b0;
            mean_i_data  <= '0;
            res_valid    <= 1'b0;
            res_data     <= '0;
            res_id       <= '0;
            err_orphan   <= 1'b0;
        end else begin
            mean_i_valid <= push;
            if (push) begin
                mean_i_data <= sel_data;
                last        <= sel_id;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      inflight <= inflight + 1'b1;
            else if (!push && pop) inflight <= inflight - 1'b1;

            res_valid <= mean_o_valid;
            if (mean_o_valid) begin
                res_data <= mean_o_data;
                res_id   <= pop ? tag_mem[rd_ptr] : '0;
            end
            if (mean_o_valid && !pop) err_orphan <= 1'b1;
        end
    end

    // NOTE: tag storage has no reset; the pointers and count define which entries are live.
    always_ff @(posedge clk) begin
        if (push) tag_mem[wr_ptr] <= sel_id;
    end

endmodule

// File: tb/tb_mean_sched.sv
// Self-checking bench for mean_sched: a queue-based model of the scheduler plus a `mean` stub,
// directed scenarios with literal expectations, then a randomized soak.

module tb_mean_sched;

    localparam int N    = 4;
    localparam int BW   = 2;
    localparam int DW   = 8;
    localparam int MAXI = 4;
    localparam int IDW  = 2;
    localparam int CW   = 3;

    logic              clk;
    logic              rst;
    logic              en;
    logic [N-1:0]      req_valid;
    logic [N-1:0]      req_ready;
    logic [N*BW*DW-1:0] req_data;
    logic              mean_i_valid;
    logic [BW*DW-1:0]  mean_i_data;
    logic              mean_o_valid;
    logic [DW-1:0]     mean_o_data;
    logic              res_valid;
    logic [DW-1:0]     res_data;
    logic [IDW-1:0]    res_id;
    logic [CW-1:0]     inflight;
    logic              err_orphan;

    mean_sched dut (
        .clk(clk), .rst(rst), .en(en),
        .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data),
        .mean_i_valid(mean_i_valid), .mean_i_data(mean_i_data),
        .mean_o_valid(mean_o_valid), .mean_o_data(mean_o_data),
        .res_valid(res_valid), .res_data(res_data), .res_id(res_id),
        .inflight(inflight), .err_orphan(err_orphan)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct { logic [IDW-1:0] id; logic [DW-1:0] val; } tag_t;
    typedef struct { logic [DW-1:0] val; int due; } pend_t;

    tag_t  m_tags[$];
    pend_t pipe[$];
    int    errors = 0;
    int    checks = 0;
    int    cyc = 0;
    int    mean_lat = 2;
    bit    stall = 0;
    bit    orph = 0;
    logic [DW-1:0] orph_data = '0;

    function automatic logic [DW-1:0] avg(input logic [BW*DW-1:0] bus);
        int s = 0;
        for (int j = 0; j < BW; j++) s += int'(bus[j*DW +: DW]);
        return DW'(s / BW);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: expected outputs derived from the arbitration and tagging rules.
    bit            live = 0;
    int            m_last;
    bit            m_err;
    logic          exp_miv;
    logic [BW*DW-1:0] exp_mid;
    logic          exp_rv;
    logic [DW-1:0] exp_rd;
    logic [IDW-1:0] exp_rid;

    always @(negedge clk) begin : cmp
        int cnt;
        int gidx;
        bit can;
        logic [N-1:0] er;
        logic [BW*DW-1:0] sl;
        tag_t tg;

        cnt  = m_tags.size();
        can  = !rst && en && ((cnt < MAXI) || ((cnt == MAXI) && mean_o_valid));
        gidx = -1;
        er   = '0;
        if (live && can)
            for (int k = 1; k <= N; k++)
                if (gidx < 0 && req_valid[(m_last + k) % N]) gidx = (m_last + k) % N;
        if (gidx >= 0) er[gidx] = 1'b1;

        if (live) begin
            check("req_ready", 32'(req_ready), 32'(er));
            check("inflight", 32'(inflight), 32'(cnt));
            check("mean_i_valid", 32'(mean_i_valid), 32'(exp_miv));
            check("mean_i_data", 32'(mean_i_data), 32'(exp_mid));
            check("res_valid", 32'(res_valid), 32'(exp_rv));
            if (exp_rv) begin
                check("res_data", 32'(res_data), 32'(exp_rd));
                check("res_id", 32'(res_id), 32'(exp_rid));
            end
            check("err_orphan", 32'(err_orphan), 32'(m_err));
        end

        if (mean_i_valid === 1'b1) pipe.push_back('{avg(mean_i_data), cyc + mean_lat});

        if (rst) begin
            live    = 1;
            m_tags.delete();
            pipe.delete();
            m_last  = N - 1;
            m_err   = 0;
            exp_miv = 0;
            exp_mid = '0;
            exp_rv  = 0;
            exp_rd  = '0;
            exp_rid = '0;
        end else if (live) begin
            exp_rv = mean_o_valid;
            if (mean_o_valid) begin
                if (cnt > 0) begin
                    tg      = m_tags.pop_front();
                    exp_rid = tg.id;
                    exp_rd  = tg.val;
                end else begin
                    exp_rid = '0;
                    exp_rd  = mean_o_data;
                    m_err   = 1;
                end
            end
            exp_miv = (gidx >= 0);
            if (gidx >= 0) begin
                sl      = req_data[gidx*BW*DW +: BW*DW];
                exp_mid = sl;
                m_last  = gidx;
                m_tags.push_back('{IDW'(gidx), avg(sl)});
            end
        end
    end

    // Advance one cycle and drive the `mean` stub outputs for it.
    task automatic step();
        pend_t p;
        @(posedge clk);
        #1;
        cyc++;
        mean_o_valid = 1'b0;
        mean_o_data  = DW'($urandom);
        if (orph) begin
            orph         = 0;
            mean_o_valid = 1'b1;
            mean_o_data  = orph_data;
        end else if (!stall && pipe.size() > 0 && pipe[0].due <= cyc) begin
            p            = pipe.pop_front();
            mean_o_valid = 1'b1;
            mean_o_data  = p.val;
        end
    endtask

    task automatic wait_neg();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        step();
        rst       = 1'b1;
        req_valid = '0;
        en        = 1'b1;
        stall     = 0;
        step();
        rst = 1'b0;
    endtask

    task automatic drain(input string name);
        bit done = 0;
        req_valid = '0;
        for (int k = 0; k < 60 && !done; k++) begin
            step();
            wait_neg();
            if (inflight == '0 && pipe.size() == 0) done = 1;
        end
        check(name, 32'(done), 32'd1);
    endtask

    initial begin : main
        int xfers;
        int extra;
        int rets;
        bit seen;

        rst = 1'b1; en = 1'b1; req_valid = '0; req_data = '0;
        mean_o_valid = 1'b0; mean_o_data = '0;

        // Single request from requester 2 with samples {4,6}
        do_reset();
        mean_lat = 3;
        req_data = '0;
        req_data[(2*BW+0)*DW +: DW] = 8'd4;
        req_data[(2*BW+1)*DW +: DW] = 8'd6;
        req_valid = 4'b0100;
        wait_neg();
        check("s1_ready", 32'(req_ready), 32'h4);
        check("s1_inflight0", 32'(inflight), 32'd0);
        step();
        req_valid = '0;
        wait_neg();
        check("s1_launch_valid", 32'(mean_i_valid), 32'd1);
        check("s1_launch_data", 32'(mean_i_data), 32'h0604);
        check("s1_inflight1", 32'(inflight), 32'd1);
        seen = 0;
        for (int k = 0; k < 20 && !seen; k++) begin
            step();
            wait_neg();
            if (res_valid) seen = 1;
        end
        check("s1_res_seen", 32'(seen), 32'd1);
        check("s1_res_data", 32'(res_data), 32'd5);
        check("s1_res_id", 32'(res_id), 32'd2);
        check("s1_inflight_end", 32'(inflight), 32'd0);

        // Round-robin fairness with all requesters active
        do_reset();
        mean_lat  = 2;
        req_valid = 4'hF;
        req_data  = {$urandom, $urandom};
        for (int i = 0; i < 12; i++) begin
            wait_neg();
            check("s2_grant", 32'(req_ready), 32'(1 << (i % N)));
            step();
            req_data = {$urandom, $urandom};
        end
        drain("s2_drain");

        // In-flight limit with the mean output stalled
        do_reset();
        stall     = 1;
        req_valid = 4'hF;
        req_data  = {$urandom, $urandom};
        xfers     = 0;
        for (int i = 0; i < 8; i++) begin
            wait_neg();
            if (req_ready != '0) xfers++;
            step();
        end
        wait_neg();
        check("s3_xfers", 32'(xfers), 32'd4);
        check("s3_ready_full", 32'(req_ready), 32'd0);
        check("s3_inflight_full", 32'(inflight), 32'd4);
        stall = 0;
        step();
        wait_neg();
        check("s3_pop_valid", 32'(mean_o_valid), 32'd1);
        check("s3_ready_on_pop", 32'(req_ready), 32'h1);
        step();
        req_valid = '0;
        wait_neg();
        check("s3_inflight_hold", 32'(inflight), 32'd4);
        drain("s3_drain");

        // Enable gating with two requests in flight
        do_reset();
        mean_lat  = 6;
        req_valid = 4'b1010;
        req_data  = {$urandom, $urandom};
        wait_neg();
        check("s4_grant1", 32'(req_ready), 32'h2);
        step();
        wait_neg();
        check("s4_grant3", 32'(req_ready), 32'h8);
        step();
        en    = 1'b0;
        extra = 0;
        rets  = 0;
        for (int k = 0; k < 15; k++) begin
            wait_neg();
            if (k > 0 && mean_i_valid) extra++;
            if (res_valid) rets++;
            step();
        end
        wait_neg();
        check("s4_no_launch", 32'(extra), 32'd0);
        check("s4_returns", 32'(rets), 32'd2);
        check("s4_inflight0", 32'(inflight), 32'd0);
        step();
        en        = 1'b1;
        req_valid = 4'hF;
        wait_neg();
        check("s4_resume", 32'(req_ready), 32'h1);
        step();
        drain("s4_drain");

        // Orphan result with an empty tag FIFO
        do_reset();
        orph      = 1;
        orph_data = 8'h3C;
        step();
        step();
        wait_neg();
        check("s5_res_valid", 32'(res_valid), 32'd1);
        check("s5_res_id", 32'(res_id), 32'd0);
        check("s5_res_data", 32'(res_data), 32'h3C);
        check("s5_err", 32'(err_orphan), 32'd1);
        check("s5_inflight", 32'(inflight), 32'd0);
        repeat (3) step();
        wait_neg();
        check("s5_err_sticky", 32'(err_orphan), 32'd1);
        do_reset();
        wait_neg();
        check("s5_err_cleared", 32'(err_orphan), 32'd0);

        // Reset while three requests are in flight
        do_reset();
        stall     = 1;
        req_valid = 4'hF;
        req_data  = {$urandom, $urandom};
        for (int i = 0; i < 3; i++) begin
            wait_neg();
            step();
        end
        req_valid = '0;
        wait_neg();
        check("s6_inflight3", 32'(inflight), 32'd3);
        step();
        rst       = 1'b1;
        req_valid = 4'hF;
        wait_neg();
        check("s6_ready_in_rst", 32'(req_ready), 32'd0);
        step();
        rst   = 1'b0;
        stall = 0;
        wait_neg();
        check("s6_inflight", 32'(inflight), 32'd0);
        check("s6_miv", 32'(mean_i_valid), 32'd0);
        check("s6_mid", 32'(mean_i_data), 32'd0);
        check("s6_rv", 32'(res_valid), 32'd0);
        check("s6_rd", 32'(res_data), 32'd0);
        check("s6_rid", 32'(res_id), 32'd0);
        check("s6_err", 32'(err_orphan), 32'd0);
        check("s6_first_grant", 32'(req_ready), 32'h1);
        step();
        drain("s6_drain");

        // Randomized soak, checked every cycle by the model
        do_reset();
        mean_lat = 2;
        for (int i = 0; i < 3000; i++) begin
            step();
            req_valid = N'($urandom);
            req_data  = {$urandom, $urandom};
            en        = ($urandom_range(0, 9) != 0);
            stall     = ($urandom_range(0, 3) == 0);
            rst       = ($urandom_range(0, 299) == 0);
        end
        step();
        rst   = 1'b0;
        en    = 1'b1;
        stall = 0;
        drain("rand_drain");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
